// File: rtl/mips_alu_pkg.sv
// Shared ALU opcode, instruction field and ID/EX control definitions
// for the MIPS ID->EX issue slice.
package mips_alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SLT = 4'b0101;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    logic       valid;
    logic [3:0] alu_op;
    logic       use_imm;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
  } id_ex_t;

endpackage

// File: rtl/id_ex_alu_issue_decode.sv
// Combinational opcode/funct decode into ALU op and pipeline controls.
// Unrecognised encodings come out as a write-free ADD.
module alu_op_decode
  import mips_alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       use_imm,
  output logic       zext,
  output logic       regwrite,
  output logic       memread,
  output logic       memwrite,
  output logic       dst_sel
);

  always_comb begin
    alu_op   = ALU_ADD;
    use_imm  = 1'b0;
    zext     = 1'b0;
    regwrite = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    dst_sel  = (opcode == OP_RTYPE);
    unique case (1'b1)
      (opcode == OP_RTYPE): begin
        unique case (1'b1)
          (funct == FN_ADD),
          (funct == FN_ADDU): begin
            alu_op   = ALU_ADD;
            regwrite = 1'b1;
          end
          (funct == FN_SUB),
          (funct == FN_SUBU): begin
            alu_op   = ALU_SUB;
            regwrite = 1'b1;
          end
          (funct == FN_AND): begin
            alu_op   = ALU_AND;
            regwrite = 1'b1;
          end
          (funct == FN_OR): begin
            alu_op   = ALU_OR;
            regwrite = 1'b1;
          end
          (funct == FN_XOR): begin
            alu_op   = ALU_XOR;
            regwrite = 1'b1;
          end
          (funct == FN_SLT): begin
            alu_op   = ALU_SLT;
            regwrite = 1'b1;
          end
          default: ;
        endcase
      end
      (opcode == OP_ADDI),
      (opcode == OP_ADDIU): begin
        use_imm  = 1'b1;
        regwrite = 1'b1;
      end
      (opcode == OP_SLTI): begin
        alu_op   = ALU_SLT;
        use_imm  = 1'b1;
        regwrite = 1'b1;
      end
      (opcode == OP_ANDI): begin
        alu_op   = ALU_AND;
        use_imm  = 1'b1;
        zext     = 1'b1;
        regwrite = 1'b1;
      end
      (opcode == OP_ORI): begin
        alu_op   = ALU_OR;
        use_imm  = 1'b1;
        zext     = 1'b1;
        regwrite = 1'b1;
      end
      (opcode == OP_XORI): begin
        alu_op   = ALU_XOR;
        use_imm  = 1'b1;
        zext     = 1'b1;
        regwrite = 1'b1;
      end
      (opcode == OP_LW): begin
        use_imm  = 1'b1;
        regwrite = 1'b1;
        memread  = 1'b1;
      end
      (opcode == OP_SW): begin
        use_imm  = 1'b1;
        memwrite = 1'b1;
      end
      (opcode == OP_BEQ): begin
        alu_op = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID->EX issue stage: decode, load-use stall, flush, ID/EX register,
// EX-side operand forwarding and a saturating stall-event counter.
module id_ex_alu_issue
  import mips_alu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   id_valid,
  output logic                   id_ready,
  input  logic [5:0]             id_opcode,
  input  logic [5:0]             id_funct,
  input  logic [4:0]             id_rs,
  input  logic [4:0]             id_rt,
  input  logic [4:0]             id_rd,
  input  logic [DATA_W-1:0]      id_rs_data,
  input  logic [DATA_W-1:0]      id_rt_data,
  input  logic [15:0]            id_imm16,
  input  logic                   flush,
  input  logic                   exmem_regwrite,
  input  logic [4:0]             exmem_rd,
  input  logic [DATA_W-1:0]      exmem_result,
  input  logic                   memwb_regwrite,
  input  logic [4:0]             memwb_rd,
  input  logic [DATA_W-1:0]      memwb_wdata,
  output logic [DATA_W-1:0]      alu_data1,
  output logic [DATA_W-1:0]      alu_data2,
  output logic [3:0]             alu_op,
  output logic                   ex_valid,
  output logic [4:0]             ex_dst,
  output logic                   ex_regwrite,
  output logic                   ex_memread,
  output logic                   ex_memwrite,
  output logic [DATA_W-1:0]      ex_store_data,
  output logic [STALL_CNT_W-1:0] stall_count
);

  logic [3:0]        dec_op;
  logic              dec_imm;
  logic              dec_zext;
  logic              dec_rw;
  logic              dec_mr;
  logic              dec_mw;
  logic              dec_dsel;
  logic              hazard;
  logic              bubble;
  logic [4:0]        nxt_dst;
  logic [DATA_W-1:0] nxt_imm;
  id_ex_t            nxt;
  id_ex_t            ex_q;
  logic [DATA_W-1:0] rs_q;
  logic [DATA_W-1:0] rt_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  alu_op_decode u_dec (
    .opcode   (id_opcode),
    .funct    (id_funct),
    .alu_op   (dec_op),
    .use_imm  (dec_imm),
    .zext     (dec_zext),
    .regwrite (dec_rw),
    .memread  (dec_mr),
    .memwrite (dec_mw),
    .dst_sel  (dec_dsel)
  );

  assign hazard = id_valid && ex_q.valid
               && ex_q.memread && (ex_q.dst != 5'd0)
               && ((ex_q.dst == id_rs)
                || (ex_q.dst == id_rt));

  // A flushed ID instruction is consumed even if it would have stalled.
  assign id_ready = flush || !hazard;
  assign bubble   = flush || hazard || !id_valid;

  assign nxt_dst = dec_dsel ? id_rd : id_rt;
  assign nxt_imm = dec_zext
    ? {{(DATA_W-16){1'b0}}, id_imm16}
    : {{(DATA_W-16){id_imm16[15]}}, id_imm16};

  always_comb begin
    nxt          = '0;
    nxt.valid    = 1'b1;
    nxt.alu_op   = dec_op;
    nxt.use_imm  = dec_imm;
    nxt.regwrite = dec_rw && (nxt_dst != 5'd0);
    nxt.memread  = dec_mr;
    nxt.memwrite = dec_mw;
    nxt.dst      = nxt_dst;
    nxt.rs       = id_rs;
    nxt.rt       = id_rt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      imm_q <= '0;
    end else if (bubble) begin
      ex_q  <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      imm_q <= '0;
    end else begin
      ex_q  <= nxt;
      rs_q  <= id_rs_data;
      rt_q  <= id_rt_data;
      imm_q <= nxt_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_count <= '0;
    else if (hazard && !flush && (stall_count != '1))
      stall_count <= stall_count + 1'b1;
  end

  always_comb begin
    fwd_rs = rs_q;
    if (exmem_regwrite && exmem_rd == ex_q.rs
        && ex_q.rs != 5'd0)
      fwd_rs = exmem_result;
    else if (memwb_regwrite && memwb_rd == ex_q.rs
             && ex_q.rs != 5'd0)
      fwd_rs = memwb_wdata;
  end

  always_comb begin
    fwd_rt = rt_q;
    if (exmem_regwrite && exmem_rd == ex_q.rt
        && ex_q.rt != 5'd0)
      fwd_rt = exmem_result;
    else if (memwb_regwrite && memwb_rd == ex_q.rt
             && ex_q.rt != 5'd0)
      fwd_rt = memwb_wdata;
  end

  assign alu_data1     = fwd_rs;
  assign alu_data2     = ex_q.use_imm ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_op        = ex_q.alu_op;
  assign ex_valid      = ex_q.valid;
  assign ex_dst        = ex_q.dst;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: each issued step pushes the
// expected EX-stage view, popped and compared after the next edge.
module tb_id_ex_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [5:0]  id_opcode = '0;
  logic [5:0]  id_funct = '0;
  logic [4:0]  id_rs = '0;
  logic [4:0]  id_rt = '0;
  logic [4:0]  id_rd = '0;
  logic [31:0] id_rs_data = '0;
  logic [31:0] id_rt_data = '0;
  logic [15:0] id_imm16 = '0;
  logic        flush = 1'b0;
  logic        exmem_regwrite = 1'b0;
  logic [4:0]  exmem_rd = '0;
  logic [31:0] exmem_result = '0;
  logic        memwb_regwrite = 1'b0;
  logic [4:0]  memwb_rd = '0;
  logic [31:0] memwb_wdata = '0;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [3:0]  alu_op;
  logic        ex_valid;
  logic [4:0]  ex_dst;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [31:0] ex_store_data;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  id_ex_alu_issue #(.DATA_W(32), .STALL_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm16(id_imm16), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd),
    .memwb_wdata(memwb_wdata),
    .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_op(alu_op), .ex_valid(ex_valid), .ex_dst(ex_dst),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data),
    .stall_count(stall_count)
  );

  typedef struct {
    logic        v;
    logic [3:0]  op;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] sd;
    logic [4:0]  dst;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic       m_v = 1'b0;
  logic       m_mr = 1'b0;
  logic [4:0] m_dst = '0;
  int         m_stall = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void mdec(
    input  logic [5:0] op, input logic [5:0] fn,
    output logic [3:0] a, output logic ui,
    output logic zx, output logic rw,
    output logic mr, output logic mw, output logic ds);
    a = 4'd0; ui = 0; zx = 0; rw = 0; mr = 0; mw = 0;
    ds = (op == 6'h00);
    case (op)
      6'h00: begin
        rw = 1;
        case (fn)
          6'h20, 6'h21: a = 4'd0;
          6'h22, 6'h23: a = 4'd1;
          6'h24: a = 4'd2;
          6'h25: a = 4'd3;
          6'h26: a = 4'd4;
          6'h2A: a = 4'd5;
          default: rw = 0;
        endcase
      end
      6'h08, 6'h09: begin ui = 1; rw = 1; end
      6'h0A: begin a = 4'd5; ui = 1; rw = 1; end
      6'h0C: begin a = 4'd2; ui = 1; zx = 1; rw = 1; end
      6'h0D: begin a = 4'd3; ui = 1; zx = 1; rw = 1; end
      6'h0E: begin a = 4'd4; ui = 1; zx = 1; rw = 1; end
      6'h23: begin ui = 1; rw = 1; mr = 1; end
      6'h2B: begin ui = 1; mw = 1; end
      6'h04: a = 4'd1;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] mfwd(input logic [4:0] r,
                                      input logic [31:0] reg_v);
    if (exmem_regwrite && exmem_rd == r && r != 0)
      return exmem_result;
    if (memwb_regwrite && memwb_rd == r && r != 0)
      return memwb_wdata;
    return reg_v;
  endfunction

  task automatic cmp_out(input exp_t e, input string t);
    chk({t, ".valid"}, 64'(ex_valid), 64'(e.v));
    chk({t, ".op"}, 64'(alu_op), 64'(e.op));
    chk({t, ".d1"}, 64'(alu_data1), 64'(e.d1));
    chk({t, ".d2"}, 64'(alu_data2), 64'(e.d2));
    chk({t, ".sd"}, 64'(ex_store_data), 64'(e.sd));
    chk({t, ".dst"}, 64'(ex_dst), 64'(e.dst));
    chk({t, ".rw"}, 64'(ex_regwrite), 64'(e.rw));
    chk({t, ".mr"}, 64'(ex_memread), 64'(e.mr));
    chk({t, ".mw"}, 64'(ex_memwrite), 64'(e.mw));
  endtask

  task automatic step(input string t, input logic v,
    input logic [5:0] op, input logic [5:0] fn,
    input logic [4:0] rs, input logic [4:0] rt,
    input logic [4:0] rd, input logic [31:0] a,
    input logic [31:0] b, input logic [15:0] imm,
    input logic fl);
    logic [3:0] dop;
    logic ui, zx, rw, mr, mw, ds, hz;
    logic [31:0] ie, rtf;
    exp_t e;
    @(negedge clk);
    id_valid = v; id_opcode = op; id_funct = fn;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = a; id_rt_data = b;
    id_imm16 = imm; flush = fl;
    #1;
    hz = v && m_v && m_mr && m_dst != 0
      && (m_dst == rs || m_dst == rt);
    chk({t, ".ready"}, 64'(id_ready), 64'(fl || !hz));
    if (hz && !fl && m_stall < 65535) m_stall++;
    mdec(op, fn, dop, ui, zx, rw, mr, mw, ds);
    ie = zx ? {16'h0, imm} : {{16{imm[15]}}, imm};
    e = '{v: 0, op: 0, d1: 0, d2: 0, sd: 0,
          dst: 0, rw: 0, mr: 0, mw: 0};
    if (v && !fl && !hz) begin
      e.v = 1; e.op = dop;
      e.dst = ds ? rd : rt;
      e.rw = rw && (e.dst != 0);
      e.mr = mr; e.mw = mw;
      e.d1 = mfwd(rs, a);
      rtf = mfwd(rt, b);
      e.sd = rtf;
      e.d2 = ui ? ie : rtf;
    end else begin
      e.d1 = mfwd(5'd0, 32'd0);
      e.sd = e.d1;
      e.d2 = e.d1;
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    cmp_out(e, t);
    chk({t, ".stall"}, 64'(stall_count), 64'(m_stall));
    m_v = e.v; m_mr = e.mr; m_dst = e.dst;
  endtask

  task automatic fwd_clear();
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_wdata = 0;
  endtask

  initial begin
    exp_t z;
    z = '{v: 0, op: 0, d1: 0, d2: 0, sd: 0,
          dst: 0, rw: 0, mr: 0, mw: 0};
    #12;
    cmp_out(z, "rst");
    chk("rst.stall", 64'(stall_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    step("add", 1, 6'h00, 6'h20, 1, 2, 3, 5, 7, 16'h0, 0);
    step("ori", 1, 6'h0D, 6'h00, 0, 4, 0, 0, 0, 16'hFFFF, 0);
    step("addi", 1, 6'h08, 6'h00, 1, 7, 0, 3, 0, 16'hFFFF, 0);
    step("lw", 1, 6'h23, 6'h00, 1, 5, 0, 9, 0, 16'h4, 0);
    step("lu_stall", 1, 6'h00, 6'h20, 5, 5, 6, 1, 1, 0, 0);
    step("lu_go", 1, 6'h00, 6'h20, 5, 5, 6, 1, 1, 0, 0);

    exmem_regwrite = 1; exmem_rd = 2; exmem_result = 32'hAA;
    memwb_regwrite = 1; memwb_rd = 2; memwb_wdata = 32'hBB;
    step("fwd_both", 1, 6'h00, 6'h22, 2, 2, 8, 3, 4, 0, 0);
    memwb_rd = 3;
    step("fwd_mix", 1, 6'h00, 6'h24, 2, 3, 8, 3, 4, 0, 0);
    exmem_rd = 0; memwb_rd = 0;
    step("fwd_r0", 1, 6'h00, 6'h25, 0, 0, 8, 3, 4, 0, 0);
    fwd_clear();

    step("lw2", 1, 6'h23, 6'h00, 1, 9, 0, 2, 0, 16'h8, 0);
    step("flush", 1, 6'h00, 6'h20, 9, 1, 10, 1, 1, 0, 1);
    step("sw", 1, 6'h2B, 6'h00, 1, 4, 0, 8, 33, 16'hFFF0, 0);
    step("beq", 1, 6'h04, 6'h00, 1, 4, 0, 8, 9, 16'h10, 0);
    step("slti", 1, 6'h0A, 6'h00, 1, 4, 0, 8, 9, 16'h8000, 0);
    step("andi", 1, 6'h0C, 6'h00, 1, 4, 0, 8, 9, 16'h8001, 0);
    step("xor", 1, 6'h00, 6'h26, 1, 2, 11, 8, 9, 0, 0);
    step("slt", 1, 6'h00, 6'h2A, 1, 2, 11, 8, 9, 0, 0);
    step("wr_r0", 1, 6'h00, 6'h20, 1, 2, 0, 8, 9, 0, 0);
    step("bad_op", 1, 6'h3F, 6'h00, 1, 2, 3, 8, 9, 0, 0);
    step("bad_fn", 1, 6'h00, 6'h3F, 1, 2, 3, 8, 9, 0, 0);
    step("idle", 0, 6'h00, 6'h20, 1, 2, 3, 8, 9, 0, 0);

    for (int i = 0; i < 24; i++) begin
      logic [5:0] ops [8];
      logic [5:0] fns [4];
      ops = '{6'h00, 6'h08, 6'h0A, 6'h0D, 6'h0E,
              6'h23, 6'h2B, 6'h04};
      fns = '{6'h20, 6'h23, 6'h25, 6'h2A};
      exmem_regwrite = 1'($urandom_range(0, 1));
      exmem_rd = 5'($urandom_range(0, 4));
      exmem_result = $urandom;
      memwb_regwrite = 1'($urandom_range(0, 1));
      memwb_rd = 5'($urandom_range(0, 4));
      memwb_wdata = $urandom;
      step("rnd", 1'($urandom_range(0, 7) != 0),
           ops[$urandom_range(0, 7)],
           fns[$urandom_range(0, 3)],
           5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
           5'($urandom_range(0, 4)), $urandom, $urandom,
           16'($urandom), 1'($urandom_range(0, 7) == 0));
    end
    fwd_clear();

    step("lw3", 1, 6'h23, 6'h00, 1, 5, 0, 9, 0, 16'h4, 0);
    @(negedge clk);
    id_valid = 1; id_opcode = 6'h00; id_funct = 6'h20;
    id_rs = 5; id_rt = 0; id_rd = 6; flush = 0;
    #1;
    chk("mid.ready", 64'(id_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    cmp_out(z, "mid_rst");
    chk("mid_rst.stall", 64'(stall_count), 64'd0);
    id_valid = 0;
    #1;
    rst_n = 1'b1;
    m_v = 0; m_mr = 0; m_dst = 0; m_stall = 0;
    @(posedge clk);
    #1;
    cmp_out(z, "post_rst");
    step("restart", 1, 6'h00, 6'h20, 5, 0, 6, 21, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
